// File: rtl/timer_pkg.sv
// Shared definitions for the minute/second timer: state encodings,
// BCD digit width, seconds limit, button indices and small BCD helpers.
package timer_pkg;

    localparam int BCD_W     = 4;
    localparam int SEC_LIMIT = 59;

    // Bit positions of the five push-button inputs inside the command vector.
    localparam int NUM_BTN   = 5;
    localparam int BTN_SEG   = 0;
    localparam int BTN_MIN   = 1;
    localparam int BTN_STOP  = 2;
    localparam int BTN_START = 3;
    localparam int BTN_DEL   = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SET    = 3'd1,
        ST_RUN_DN = 3'd2,
        ST_RUN_UP = 3'd3,
        ST_PAUSE  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Two BCD digits packed as {tens, ones}.
    typedef logic [2*BCD_W-1:0] bcd2_t;

    // Convert a small integer (0..99) to a packed two-digit BCD value.
    function automatic bcd2_t to_bcd2(input int v);
        return {BCD_W'(v / 10), BCD_W'(v % 10)};
    endfunction

    // Two-digit BCD increment; caller handles the upper wrap point.
    function automatic bcd2_t bcd2_inc(input bcd2_t v);
        logic [BCD_W-1:0] t;
        logic [BCD_W-1:0] o;
        t = v[2*BCD_W-1:BCD_W];
        o = v[BCD_W-1:0];
        if (o == BCD_W'(9)) begin
            return {t + BCD_W'(1), BCD_W'(0)};
        end
        return {t, o + BCD_W'(1)};
    endfunction

    // Two-digit BCD decrement; caller handles the 00 wrap point.
    function automatic bcd2_t bcd2_dec(input bcd2_t v);
        logic [BCD_W-1:0] t;
        logic [BCD_W-1:0] o;
        t = v[2*BCD_W-1:BCD_W];
        o = v[BCD_W-1:0];
        if (o == BCD_W'(0)) begin
            return {t - BCD_W'(1), BCD_W'(9)};
        end
        return {t, o - BCD_W'(1)};
    endfunction

endpackage

// File: rtl/bcd_mmss_counter.sv
// Four-digit MM:SS BCD register bank. Supports clear, independent
// set-mode increments (no carry between fields) and run-mode tick
// increment/decrement with carry/borrow between seconds and minutes.
module bcd_mmss_counter
    import timer_pkg::*;
#(
    parameter int MIN_MAX = 99
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc_sec_wrap,
    input  logic             inc_min_wrap,
    input  logic             tick_up,
    input  logic             tick_dn,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             is_zero,
    output logic             is_max
);

    localparam bcd2_t MIN_MAX_BCD = to_bcd2(MIN_MAX);
    localparam bcd2_t SEC_MAX_BCD = to_bcd2(SEC_LIMIT);

    bcd2_t r_min;
    bcd2_t r_sec;
    bcd2_t w_min_next;
    bcd2_t w_sec_next;

    // Next-value selection; the controller guarantees at most one request per cycle,
    // the if-chain simply gives clear the final say.
    always_comb begin
        w_min_next = r_min;
        w_sec_next = r_sec;
        if (clear) begin
            w_min_next = '0;
            w_sec_next = '0;
        end else if (inc_sec_wrap) begin
            w_sec_next = (r_sec == SEC_MAX_BCD) ? bcd2_t'(0) : bcd2_inc(r_sec);
        end else if (inc_min_wrap) begin
            w_min_next = (r_min == MIN_MAX_BCD) ? bcd2_t'(0) : bcd2_inc(r_min);
        end else if (tick_up) begin
            if (r_sec == SEC_MAX_BCD) begin
                w_sec_next = '0;
                w_min_next = (r_min == MIN_MAX_BCD) ? bcd2_t'(0) : bcd2_inc(r_min);
            end else begin
                w_sec_next = bcd2_inc(r_sec);
            end
        end else if (tick_dn) begin
            if (r_sec == bcd2_t'(0)) begin
                w_sec_next = SEC_MAX_BCD;
                w_min_next = (r_min == bcd2_t'(0)) ? MIN_MAX_BCD : bcd2_dec(r_min);
            end else begin
                w_sec_next = bcd2_dec(r_sec);
            end
        end
    end

    // Digit registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_min <= '0;
            r_sec <= '0;
        end else begin
            r_min <= w_min_next;
            r_sec <= w_sec_next;
        end
    end

    assign min_tens = r_min[2*BCD_W-1:BCD_W];
    assign min_ones = r_min[BCD_W-1:0];
    assign sec_tens = r_sec[2*BCD_W-1:BCD_W];
    assign sec_ones = r_sec[BCD_W-1:0];
    assign is_zero  = (r_min == bcd2_t'(0)) && (r_sec == bcd2_t'(0));
    assign is_max   = (r_min == MIN_MAX_BCD) && (r_sec == SEC_MAX_BCD);

endmodule

// File: rtl/timer_controller.sv
// Minute/second timer controller: button edge detection with priority,
// IDLE/SET/RUN_DN/RUN_UP/PAUSE/DONE state machine, one-second prescaler
// and a finite alarm window after count-down expiry.
module timer_controller
    import timer_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int MIN_MAX     = 99,
    parameter int ALARM_TICKS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       delete,
    input  logic       seg_demand,
    input  logic       min_demand,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [2:0] state,
    output logic       running,
    output logic       finished,
    output logic       alarm
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (ALARM_TICKS > 0) ? $clog2(ALARM_TICKS + 1) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'((ALARM_TICKS > 0) ? ALARM_TICKS - 1 : 0);
    localparam logic          ALARM_EN   = (ALARM_TICKS > 0);
    localparam bcd2_t MIN_MAX_BCD  = to_bcd2(MIN_MAX);
    localparam bcd2_t SEC_PRE_BCD  = to_bcd2(SEC_LIMIT - 1);

    // ------------------------------------------------------------------
    // Edge detection: sample, delay, then register the rising-edge pulse.
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] w_btn;
    logic [NUM_BTN-1:0] w_cmd;

    assign w_btn[BTN_SEG]   = seg_demand;
    assign w_btn[BTN_MIN]   = min_demand;
    assign w_btn[BTN_STOP]  = stop;
    assign w_btn[BTN_START] = start;
    assign w_btn[BTN_DEL]   = delete;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_edge
            logic r_in;
            logic r_in_q;
            logic r_cmd;
            // Register the level, its previous value, and the one-cycle command pulse.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_in   <= 1'b0;
                    r_in_q <= 1'b0;
                    r_cmd  <= 1'b0;
                end else begin
                    r_in   <= w_btn[gi];
                    r_in_q <= r_in;
                    r_cmd  <= r_in & ~r_in_q;
                end
            end
            assign w_cmd[gi] = r_cmd;
        end
    endgenerate

    // Only the highest-priority edge is acted on in a given cycle.
    logic w_do_del;
    logic w_do_start;
    logic w_do_stop;
    logic w_do_min;
    logic w_do_sec;

    assign w_do_del   = w_cmd[BTN_DEL];
    assign w_do_start = w_cmd[BTN_START] & ~w_cmd[BTN_DEL];
    assign w_do_stop  = w_cmd[BTN_STOP]  & ~|w_cmd[BTN_DEL:BTN_START];
    assign w_do_min   = w_cmd[BTN_MIN]   & ~|w_cmd[BTN_DEL:BTN_STOP];
    assign w_do_sec   = w_cmd[BTN_SEG]   & ~|w_cmd[BTN_DEL:BTN_MIN];

    // ------------------------------------------------------------------
    // Time digits
    // ------------------------------------------------------------------
    logic w_clear;
    logic w_inc_sec;
    logic w_inc_min;
    logic w_tick_up;
    logic w_tick_dn;
    logic w_is_zero;
    logic w_is_max;
    logic [3:0] w_min_tens;
    logic [3:0] w_min_ones;
    logic [3:0] w_sec_tens;
    logic [3:0] w_sec_ones;

    bcd_mmss_counter #(
        .MIN_MAX (MIN_MAX)
    ) u_counter (
        .clk          (clk),
        .reset        (reset),
        .clear        (w_clear),
        .inc_sec_wrap (w_inc_sec),
        .inc_min_wrap (w_inc_min),
        .tick_up      (w_tick_up),
        .tick_dn      (w_tick_dn),
        .min_tens     (w_min_tens),
        .min_ones     (w_min_ones),
        .sec_tens     (w_sec_tens),
        .sec_ones     (w_sec_ones),
        .is_zero      (w_is_zero),
        .is_max       (w_is_max)
    );

    // Time values one tick away from the terminal points, so the tick that
    // lands on 00:00 or MIN_MAX:59 also moves the FSM into DONE.
    logic w_dn_last;
    logic w_up_last;

    assign w_dn_last = ({w_min_tens, w_min_ones} == bcd2_t'(0)) &&
                       ({w_sec_tens, w_sec_ones} == bcd2_t'(1));
    assign w_up_last = ({w_min_tens, w_min_ones} == MIN_MAX_BCD) &&
                       ({w_sec_tens, w_sec_ones} == SEC_PRE_BCD);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_next;
    logic   r_mode_up;
    logic   w_mode_next;
    logic   r_running;
    logic   r_finished;
    logic   r_alarm;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] r_alarm_div;
    logic [AW-1:0] r_alarm_cnt;
    logic   w_run_now;
    logic   w_run_next;
    logic   w_tick;
    logic   w_alarm_start;

    assign w_run_now  = (r_state == ST_RUN_DN) || (r_state == ST_RUN_UP);
    assign w_run_next = (w_state_next == ST_RUN_DN) || (w_state_next == ST_RUN_UP);
    assign w_tick     = w_run_now && (r_presc == PRESC_LAST);

    // Next-state and counter-request decode.
    always_comb begin
        w_state_next = r_state;
        w_mode_next  = r_mode_up;
        w_clear      = 1'b0;
        w_inc_sec    = 1'b0;
        w_inc_min    = 1'b0;
        w_tick_up    = 1'b0;
        w_tick_dn    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_do_del) begin
                    w_clear = 1'b1;
                end else if (w_do_start) begin
                    w_state_next = ST_RUN_UP;
                    w_mode_next  = 1'b1;
                end else if (w_do_min) begin
                    w_state_next = ST_SET;
                    w_inc_min    = 1'b1;
                end else if (w_do_sec) begin
                    w_state_next = ST_SET;
                    w_inc_sec    = 1'b1;
                end
            end
            ST_SET: begin
                if (w_do_del) begin
                    w_state_next = ST_IDLE;
                    w_clear      = 1'b1;
                end else if (w_do_start) begin
                    w_state_next = w_is_zero ? ST_RUN_UP : ST_RUN_DN;
                    w_mode_next  = w_is_zero;
                end else if (w_do_min) begin
                    w_inc_min = 1'b1;
                end else if (w_do_sec) begin
                    w_inc_sec = 1'b1;
                end
            end
            ST_RUN_DN: begin
                if (w_do_del) begin
                    w_state_next = ST_IDLE;
                    w_clear      = 1'b1;
                end else if (w_do_stop) begin
                    w_state_next = ST_PAUSE;
                end else if (w_is_zero) begin
                    w_state_next = ST_DONE;
                end else if (w_tick) begin
                    w_tick_dn = 1'b1;
                    if (w_dn_last) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_RUN_UP: begin
                if (w_do_del) begin
                    w_state_next = ST_IDLE;
                    w_clear      = 1'b1;
                end else if (w_do_stop) begin
                    w_state_next = ST_PAUSE;
                end else if (w_is_max) begin
                    w_state_next = ST_DONE;
                end else if (w_tick) begin
                    w_tick_up = 1'b1;
                    if (w_up_last) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_PAUSE: begin
                if (w_do_del) begin
                    w_state_next = ST_IDLE;
                    w_clear      = 1'b1;
                end else if (w_do_start) begin
                    w_state_next = r_mode_up ? ST_RUN_UP : ST_RUN_DN;
                end
            end
            ST_DONE: begin
                if (w_do_del || w_do_start) begin
                    w_state_next = ST_IDLE;
                    w_clear      = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_clear      = 1'b1;
            end
        endcase
    end

    assign w_alarm_start = ALARM_EN && (r_state == ST_RUN_DN) && (w_state_next == ST_DONE);

    // State, run mode and registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_mode_up  <= 1'b0;
            r_running  <= 1'b0;
            r_finished <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_mode_up  <= w_mode_next;
            r_running  <= w_run_next;
            r_finished <= (w_state_next == ST_DONE);
        end
    end

    // One-second prescaler: restarts on every entry into a run state, holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_run_next && !w_run_now) begin
            r_presc <= '0;
        end else if (w_run_now && w_run_next) begin
            r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + 1'b1;
        end
    end

    // Alarm window: its own sub-second divider and a count of elapsed seconds in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alarm     <= 1'b0;
            r_alarm_div <= '0;
            r_alarm_cnt <= '0;
        end else if (w_alarm_start) begin
            r_alarm     <= 1'b1;
            r_alarm_div <= '0;
            r_alarm_cnt <= '0;
        end else if (w_state_next != ST_DONE) begin
            r_alarm <= 1'b0;
        end else if (r_alarm) begin
            if (r_alarm_div == PRESC_LAST) begin
                r_alarm_div <= '0;
                if (r_alarm_cnt == ALARM_LAST) begin
                    r_alarm <= 1'b0;
                end else begin
                    r_alarm_cnt <= r_alarm_cnt + 1'b1;
                end
            end else begin
                r_alarm_div <= r_alarm_div + 1'b1;
            end
        end
    end

    assign min_tens = w_min_tens;
    assign min_ones = w_min_ones;
    assign sec_tens = w_sec_tens;
    assign sec_ones = w_sec_ones;
    assign state    = r_state;
    assign running  = r_running;
    assign finished = r_finished;
    assign alarm    = r_alarm;

endmodule
